// File: rtl/inert_seq_intf.sv
`default_nettype none
// ============================================================================
// Module   : inert_seq_intf
// Purpose  : Inertial-sensor SPI sequencer: wake wait, init writes, then an
//            atomic multi-byte read burst on every sensor data-ready edge.
// Revision : 1.0 - initial release
// ============================================================================
module inert_seq_intf #(
    parameter int                   N_INIT    = 4,
    parameter logic [16*N_INIT-1:0] INIT_CMDS = 64'h1460_1150_1053_0D02,
    parameter int                   N_RD      = 4,
    parameter logic [8*N_RD-1:0]    RD_ADDRS  = 32'hAD_AC_A3_A2,
    parameter int                   WAKE_BITS = 16,
    parameter int                   TO_CYC    = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                INT,
    input  logic                done,
    input  logic [15:0]         rd_data,
    input  logic                clr_ovr,
    output logic                wrt,
    output logic [15:0]         cmd,
    output logic [8*N_RD-1:0]   data,
    output logic                vld,
    output logic                init_done,
    output logic                ovr,
    output logic                err
);

    localparam int c_MAXN  = (N_INIT > N_RD) ? N_INIT : N_RD;
    localparam int c_IDX_W = (c_MAXN > 1) ? $clog2(c_MAXN) : 1;
    localparam int c_TO_W  = $clog2(TO_CYC);
    localparam logic [c_TO_W-1:0]  c_TO_HIT   = c_TO_W'(TO_CYC - 2);
    localparam logic [c_IDX_W-1:0] c_INIT_LST = c_IDX_W'(N_INIT - 1);
    localparam logic [c_IDX_W-1:0] c_RD_LST   = c_IDX_W'(N_RD - 1);

    typedef enum logic [2:0] {
        S_WAKE  = 3'd0,
        S_INIT  = 3'd1,
        S_IDLE  = 3'd2,
        S_READ  = 3'd3,
        S_VALID = 3'd4
    } state_t;

    state_t                r_state, w_state;
    logic [WAKE_BITS-1:0]  r_wake_cnt, w_wake_cnt;
    logic [c_TO_W-1:0]     r_to_cnt, w_to_cnt;
    logic [c_IDX_W-1:0]    r_idx, w_idx;
    logic [8*N_RD-1:0]     r_stage, w_stage, w_stage_upd;
    logic [8*N_RD-1:0]     r_data, w_data;
    logic [15:0]           r_cmd, w_cmd;
    logic                  r_wrt, w_wrt;
    logic                  r_vld, w_vld;
    logic                  r_init_done, w_init_done;
    logic                  r_ovr, w_ovr;
    logic                  r_err, w_err;
    logic                  r_int_meta, r_int_sync, r_int_prev;
    logic                  w_int_re;
    logic                  w_to_hit;
    logic                  w_unused;

    // Only the low byte of each read carries register content.
    assign w_unused = ^rd_data[15:8];

    function automatic logic [15:0] f_init_cmd(input logic [c_IDX_W-1:0] i);
        f_init_cmd = '0;
        for (int k = 0; k < N_INIT; k++)
            if (i == c_IDX_W'(k)) f_init_cmd = INIT_CMDS[16*k +: 16];
    endfunction

    function automatic logic [15:0] f_rd_cmd(input logic [c_IDX_W-1:0] i);
        f_rd_cmd = '0;
        for (int k = 0; k < N_RD; k++)
            if (i == c_IDX_W'(k)) f_rd_cmd = {RD_ADDRS[8*k +: 8], 8'h00};
    endfunction

    assign w_int_re = r_int_sync & ~r_int_prev;
    assign w_to_hit = (r_to_cnt == c_TO_HIT);

    always_comb begin
        w_stage_upd = r_stage;
        for (int k = 0; k < N_RD; k++)
            if (r_idx == c_IDX_W'(k)) w_stage_upd[8*k +: 8] = rd_data[7:0];
    end

    always_comb begin
        w_state     = r_state;
        w_wake_cnt  = r_wake_cnt;
        w_to_cnt    = r_to_cnt;
        w_idx       = r_idx;
        w_stage     = r_stage;
        w_data      = r_data;
        w_cmd       = r_cmd;
        w_wrt       = 1'b0;
        w_vld       = 1'b0;
        w_err       = 1'b0;
        w_init_done = r_init_done;
        w_ovr       = r_ovr & ~clr_ovr;
        if (w_int_re && (r_state == S_READ || r_state == S_VALID))
            w_ovr = 1'b1;

        case (r_state)
            S_WAKE: begin
                w_wake_cnt = r_wake_cnt + 1'b1;
                if (&r_wake_cnt) begin
                    w_wrt    = 1'b1;
                    w_cmd    = f_init_cmd('0);
                    w_idx    = '0;
                    w_to_cnt = '0;
                    w_state  = S_INIT;
                end
            end
            S_INIT: begin
                if (done) begin
                    if (r_idx == c_INIT_LST) begin
                        w_init_done = 1'b1;
                        w_cmd       = '0;
                        w_state     = S_IDLE;
                    end else begin
                        w_wrt    = 1'b1;
                        w_idx    = r_idx + 1'b1;
                        w_cmd    = f_init_cmd(r_idx + 1'b1);
                        w_to_cnt = '0;
                    end
                end else if (w_to_hit) begin
                    // Sensor stopped answering: replay the whole init list.
                    w_err    = 1'b1;
                    w_wrt    = 1'b1;
                    w_idx    = '0;
                    w_cmd    = f_init_cmd('0);
                    w_to_cnt = '0;
                end else begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                w_cmd = '0;
                if (w_int_re) begin
                    w_wrt    = 1'b1;
                    w_cmd    = f_rd_cmd('0);
                    w_idx    = '0;
                    w_to_cnt = '0;
                    w_state  = S_READ;
                end
            end
            S_READ: begin
                if (done) begin
                    w_stage = w_stage_upd;
                    if (r_idx == c_RD_LST) begin
                        w_data  = w_stage_upd;
                        w_vld   = 1'b1;
                        w_cmd   = '0;
                        w_state = S_VALID;
                    end else begin
                        w_wrt    = 1'b1;
                        w_idx    = r_idx + 1'b1;
                        w_cmd    = f_rd_cmd(r_idx + 1'b1);
                        w_to_cnt = '0;
                    end
                end else if (w_to_hit) begin
                    w_err   = 1'b1;
                    w_stage = '0;
                    w_cmd   = '0;
                    w_state = S_IDLE;
                end else begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end
            S_VALID: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_WAKE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_WAKE;
            r_wake_cnt  <= '0;
            r_to_cnt    <= '0;
            r_idx       <= '0;
            r_stage     <= '0;
            r_data      <= '0;
            r_cmd       <= '0;
            r_wrt       <= 1'b0;
            r_vld       <= 1'b0;
            r_init_done <= 1'b0;
            r_ovr       <= 1'b0;
            r_err       <= 1'b0;
            r_int_meta  <= 1'b0;
            r_int_sync  <= 1'b0;
            r_int_prev  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_wake_cnt  <= w_wake_cnt;
            r_to_cnt    <= w_to_cnt;
            r_idx       <= w_idx;
            r_stage     <= w_stage;
            r_data      <= w_data;
            r_cmd       <= w_cmd;
            r_wrt       <= w_wrt;
            r_vld       <= w_vld;
            r_init_done <= w_init_done;
            r_ovr       <= w_ovr;
            r_err       <= w_err;
            r_int_meta  <= INT;
            r_int_sync  <= r_int_meta;
            r_int_prev  <= r_int_sync;
        end
    end

    assign wrt       = r_wrt;
    assign cmd       = r_cmd;
    assign data      = r_data;
    assign vld       = r_vld;
    assign init_done = r_init_done;
    assign ovr       = r_ovr;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_inert_seq_intf.sv
`default_nettype none
// ============================================================================
// Module   : tb_inert_seq_intf
// Purpose  : Directed self-checking bench for inert_seq_intf (4- and 6-read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inert_seq_intf;

    logic        clk = 1'b0, rst_n = 1'b0, INT = 1'b0, clr_ovr = 1'b0;
    logic        done4 = 1'b0, done6 = 1'b0;
    logic [15:0] rd4 = '0, rd6 = '0;
    logic        wrt4, wrt6, vld4, vld6, ind4, ind6, ovr4, ovr6, err4, err6;
    logic [15:0] cmd4, cmd6;
    logic [31:0] data4;
    logic [47:0] data6;

    int errors = 0, checks = 0, cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inert_seq_intf #(.WAKE_BITS(4), .TO_CYC(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done4), .rd_data(rd4),
        .clr_ovr(clr_ovr), .wrt(wrt4), .cmd(cmd4), .data(data4), .vld(vld4),
        .init_done(ind4), .ovr(ovr4), .err(err4));

    inert_seq_intf #(.N_RD(6), .RD_ADDRS(48'hAD_AC_A9_A8_A3_A2),
                     .WAKE_BITS(4), .TO_CYC(16)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done6), .rd_data(rd6),
        .clr_ovr(clr_ovr), .wrt(wrt6), .cmd(cmd6), .data(data6), .vld(vld6),
        .init_done(ind6), .ovr(ovr6), .err(err6));

    // SPI slave models: answer 8 cycles after wrt, byte chosen by address
    logic [7:0] bytes4 [4];
    logic [7:0] drop4 = 8'hFF, cur4 = '0, cur6 = '0;
    int pend4 = 0, pend6 = 0, done4_cyc = 0;

    function automatic logic [7:0] f_byte4(input logic [7:0] a);
        case (a)
            8'hA2:   return bytes4[0];
            8'hA3:   return bytes4[1];
            8'hAC:   return bytes4[2];
            8'hAD:   return bytes4[3];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] f_byte6(input logic [7:0] a);
        case (a)
            8'hA2:   return 8'h11;
            8'hA3:   return 8'h22;
            8'hA8:   return 8'h33;
            8'hA9:   return 8'h44;
            8'hAC:   return 8'h55;
            8'hAD:   return 8'h66;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        done4 = 1'b0;
        if (pend4 > 0) begin
            pend4 = pend4 - 1;
            if (pend4 == 0 && cur4 != drop4) begin
                done4     = 1'b1;
                rd4       = {8'hEE, f_byte4(cur4)};
                done4_cyc = cyc;
            end
        end
        if (wrt4) begin
            pend4 = 8;
            cur4  = cmd4[15:8];
        end
        done6 = 1'b0;
        if (pend6 > 0) begin
            pend6 = pend6 - 1;
            if (pend6 == 0) begin
                done6 = 1'b1;
                rd6   = {8'h5A, f_byte6(cur6)};
            end
        end
        if (wrt6) begin
            pend6 = 8;
            cur6  = cmd6[15:8];
        end
    end

    logic [15:0] cmdq4[$], cmdq6[$];
    int wrt4_cnt = 0, wrt4_cyc = 0, vld4_cnt = 0, vld4_cyc = 0;
    int err4_cnt = 0, err4_cyc = 0, chg4_cnt = 0, ind4_cyc = 0, vld6_cnt = 0;
    logic [31:0] prev4 = '0;
    logic        ind4_prev = 1'b0;

    always @(negedge clk) begin
        if (wrt4) begin wrt4_cnt++; wrt4_cyc = cyc; cmdq4.push_back(cmd4); end
        if (vld4) begin vld4_cnt++; vld4_cyc = cyc; end
        if (err4) begin err4_cnt++; err4_cyc = cyc; end
        if (data4 !== prev4) chg4_cnt++;
        prev4 = data4;
        if (ind4 && !ind4_prev) ind4_cyc = cyc;
        ind4_prev = ind4;
        if (wrt6) cmdq6.push_back(cmd6);
        if (vld6) vld6_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int f_probe(input int which);
        case (which)
            0:       return wrt4_cnt;
            1:       return vld4_cnt;
            2:       return err4_cnt;
            3:       return int'(ind4);
            4:       return vld6_cnt;
            default: return 0;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int target, input int lim);
        int n = 0;
        while (f_probe(which) < target && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (f_probe(which) < target) begin
            checks++;
            errors++;
            $display("FAIL %s: wait expired after %0d cycles", name, lim);
        end
        @(negedge clk);
    endtask

    task automatic pulse_int();
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  b_a2, b_a3, b_ac, b_ad;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];
    int   rel, base, w0, v0, e0, c0;
    logic [31:0] last;

    initial begin
        vecs[0] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 32'hABCD1234};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        vecs[2] = '{8'hFF, 8'h01, 8'h80, 8'h7F, 32'h7F8001FF};
        vecs[3] = '{8'h5A, 8'hA5, 8'hC3, 8'h3C, 32'h3CC3A55A};
        bytes4 = '{8'h00, 8'h00, 8'h00, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wrt", wrt4, 0);
        chk("rst_outs", {cmd4, vld4, ind4, ovr4, err4}, 0);
        chk("rst_data", data4, 0);

        // Wake wait, then init writes in order
        rst_n = 1'b1;
        rel = cyc;
        wait_for("wake_wrt", 0, 1, 100);
        chk("wake_len", wrt4_cyc, rel + 16);
        wait_for("init_done", 3, 1, 200);
        chk("init_cmd0", cmdq4[0], 16'h0D02);
        chk("init_cmd1", cmdq4[1], 16'h1053);
        chk("init_cmd2", cmdq4[2], 16'h1150);
        chk("init_cmd3", cmdq4[3], 16'h1460);
        chk("init_done_time", ind4_cyc, done4_cyc + 1);
        repeat (40) @(negedge clk);
        chk("no_5th_wrt", wrt4_cnt, 4);
        chk("idle_cmd", cmd4, 0);

        // Read bursts from the table
        for (int i = 0; i < 4; i++) begin
            bytes4 = '{vecs[i].b_a2, vecs[i].b_a3, vecs[i].b_ac, vecs[i].b_ad};
            base = cmdq4.size();
            v0 = vld4_cnt;
            c0 = chg4_cnt;
            pulse_int();
            wait_for("burst_vld", 1, v0 + 1, 200);
            chk($sformatf("v%0d_data", i), data4, vecs[i].exp);
            chk($sformatf("v%0d_cmd0", i), cmdq4[base],     16'hA200);
            chk($sformatf("v%0d_cmd1", i), cmdq4[base + 1], 16'hA300);
            chk($sformatf("v%0d_cmd2", i), cmdq4[base + 2], 16'hAC00);
            chk($sformatf("v%0d_cmd3", i), cmdq4[base + 3], 16'hAD00);
            chk($sformatf("v%0d_vld_lat", i), vld4_cyc, done4_cyc + 1);
            repeat (80) @(negedge clk);
            chk($sformatf("v%0d_one_vld", i), vld4_cnt, v0 + 1);
            chk($sformatf("v%0d_atomic", i), chg4_cnt - c0, 1);
            chk($sformatf("v%0d_hold", i), data4, vecs[i].exp);
            if (i == 0) begin
                chk("n6_vld", vld6_cnt, 1);
                chk("n6_data", data6, 48'h665544332211);
                chk("n6_cmd2", cmdq6[6], 16'hA800);
                chk("n6_cmd5", cmdq6[9], 16'hAD00);
            end
        end
        last = vecs[3].exp;

        // Held INT level triggers once
        w0 = wrt4_cnt;
        v0 = vld4_cnt;
        INT = 1'b1;
        repeat (10000) @(negedge clk);
        chk("held_vld", vld4_cnt, v0 + 1);
        chk("held_wrt", wrt4_cnt, w0 + 4);
        INT = 1'b0;
        repeat (5) @(negedge clk);

        // Overrun: edge mid-burst, burst completes, edge not queued
        w0 = wrt4_cnt;
        v0 = vld4_cnt;
        INT = 1'b1;
        wait_for("ovr_wrt", 0, w0 + 2, 100);
        INT = 1'b0;
        repeat (3) @(negedge clk);
        pulse_int();
        wait_for("ovr_vld", 1, v0 + 1, 200);
        repeat (80) @(negedge clk);
        chk("ovr_set", ovr4, 1);
        chk("ovr_one_vld", vld4_cnt, v0 + 1);
        chk("ovr_wrts", wrt4_cnt, w0 + 4);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("ovr_clr", ovr4, 0);

        // Overrun and clear in the same cycle
        w0 = wrt4_cnt;
        v0 = vld4_cnt;
        INT = 1'b1;
        wait_for("ovr2_wrt", 0, w0 + 2, 100);
        INT = 1'b0;
        repeat (3) @(negedge clk);
        INT = 1'b1;
        repeat (2) @(negedge clk);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("ovr_set_wins", ovr4, 1);
        INT = 1'b0;
        wait_for("ovr2_vld", 1, v0 + 1, 200);
        repeat (80) @(negedge clk);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;

        // Timeout on third read
        drop4 = 8'hAC;
        w0 = wrt4_cnt;
        v0 = vld4_cnt;
        e0 = err4_cnt;
        base = cmdq4.size();
        pulse_int();
        wait_for("to_err", 2, e0 + 1, 200);
        chk("to_cmd", cmdq4[base + 2], 16'hAC00);
        chk("to_err_time", err4_cyc, wrt4_cyc + 15);
        repeat (60) @(negedge clk);
        chk("to_one_err", err4_cnt, e0 + 1);
        chk("to_no_vld", vld4_cnt, v0);
        chk("to_data_kept", data4, last);
        chk("to_wrts", wrt4_cnt, w0 + 3);
        chk("to_idle_cmd", cmd4, 0);
        drop4 = 8'hFF;
        bytes4 = '{8'h01, 8'h02, 8'h03, 8'h04};
        base = cmdq4.size();
        v0 = vld4_cnt;
        pulse_int();
        wait_for("to_next_vld", 1, v0 + 1, 200);
        chk("to_fresh_cmd", cmdq4[base], 16'hA200);
        chk("to_fresh_data", data4, 32'h04030201);
        repeat (80) @(negedge clk);

        // Reset during READ
        w0 = wrt4_cnt;
        pulse_int();
        wait_for("rr_wrt", 0, w0 + 2, 100);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rr_outs", {wrt4, cmd4, vld4, ind4, ovr4, err4}, 0);
        chk("rr_data", data4, 0);
        chk("rr_data6", data6, 0);
        rst_n = 1'b1;
        rel = cyc;
        w0 = wrt4_cnt;
        wait_for("rr_wake", 0, w0 + 1, 100);
        chk("rr_wake_len", wrt4_cyc, rel + 16);
        chk("rr_cmd", cmdq4[cmdq4.size() - 1], 16'h0D02);

        // Reset during INIT
        wait_for("ri_wrt", 0, w0 + 2, 100);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("ri_outs", {wrt4, cmd4, vld4, ind4, ovr4, err4}, 0);
        rst_n = 1'b1;
        rel = cyc;
        w0 = wrt4_cnt;
        wait_for("ri_wake", 0, w0 + 1, 100);
        chk("ri_wake_len", wrt4_cyc, rel + 16);
        wait_for("ri_init_done", 3, 1, 200);
        base = cmdq4.size();
        chk("ri_last_cmd", cmdq4[base - 1], 16'h1460);
        chk("ri_wrts", wrt4_cnt, w0 + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
